// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned PC_STEP        = 4;
    localparam int unsigned DEFAULT_ADDR_W = 32;

    typedef struct packed {
        logic [INSTR_W-1:0]        word;
        logic [DEFAULT_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; wrap bit on each pointer
// separates full from empty, head is read straight from the storage registers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        full;
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count   = wr_ptr - rd_ptr;
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr[AW-1:0]];
    end

    // Storage is cleared on reset so the presented word/pc read as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order memory
// requests, queues returned words and handles redirects by flush-and-drop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0] word;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         expect_pc;
    logic [ADDR_W-1:0]         redirect_target;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             drop_cnt;
    logic [$clog2(DEPTH):0]    occupancy;
    logic [CW:0]               credit_sum;
    logic                      req_fire;
    logic                      rsp_drop;
    logic                      rsp_push;
    logic                      pop;
    logic                      fifo_empty;
    entry_t                    push_entry;
    entry_t                    head;
    logic                      unused_redirect_lsbs;

    always_comb begin
        redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
        unused_redirect_lsbs = ^redirect_pc[1:0];
        credit_sum           = (CW+1)'(outstanding) + (CW+1)'(occupancy);
        imem_req_valid       = !reset && (credit_sum < (CW+1)'(DEPTH)) && !redirect_valid;
        imem_req_addr        = pc;
        req_fire             = imem_req_valid && imem_req_ready;
        // A response landing in the redirect cycle is stale and dropped on the spot.
        rsp_drop             = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
        rsp_push             = imem_rsp_valid && !rsp_drop;
        push_entry.word      = imem_rsp_data;
        push_entry.pc        = expect_pc;
        instr_valid          = !fifo_empty;
        instr                = head.word;
        instr_pc             = head.pc;
        pop                  = instr_valid && instr_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            expect_pc   <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc        <= redirect_target;
                expect_pc <= redirect_target;
                drop_cnt  <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + ADDR_W'(PC_STEP);
                end
                if (rsp_push) begin
                    expect_pc <= expect_pc + ADDR_W'(PC_STEP);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory with configurable latency
// and a transaction-level model (epoch-tagged requests, expected instruction queue).
module tb_fetch_unit;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_unit #(
        .ADDR_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int unsigned epoch; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;

    infl_t m_infl[$];
    ent_t  m_q[$];
    mreq_t mem_q[$];
    logic [31:0] m_pc = RST_PC;
    int unsigned epoch = 0;

    int unsigned cyc = 0, n_checks = 0, n_fail = 0, fires = 0;
    int unsigned p_rr = 100, p_ir = 100, p_redir = 0, p_rst = 0, lat = 1;
    logic        force_reset = 1'b0, force_redir = 1'b0;
    logic [31:0] force_target = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic  was_reset, exp_iv, exp_rv, fire_exp;
        infl_t f;
        @(posedge clk);
        #1;
        was_reset      = reset;
        reset          = force_reset || ($urandom_range(99) < p_rst);
        force_reset    = 1'b0;
        redirect_valid = force_redir || ($urandom_range(99) < p_redir);
        redirect_pc    = force_redir ? force_target : $urandom();
        force_redir    = 1'b0;
        imem_req_ready = ($urandom_range(99) < p_rr);
        instr_ready    = ($urandom_range(99) < p_ir);
        if (!reset && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        @(negedge clk);

        exp_iv = (m_q.size() != 0);
        exp_rv = !reset && ((m_infl.size() + m_q.size()) < DEPTH) && !redirect_valid;
        check("instr_valid", instr_valid, exp_iv);
        if (exp_iv) begin
            check("instr", instr, m_q[0].word);
            check("instr_pc", instr_pc, m_q[0].pc);
        end
        if (was_reset) begin
            check("reset_instr", instr, 0);
            check("reset_instr_pc", instr_pc, 0);
        end
        check("req_valid", imem_req_valid, exp_rv);
        check("req_addr", imem_req_addr, m_pc);
        if (imem_req_valid && imem_req_ready) fires++;

        if (reset) begin
            m_q.delete();
            m_infl.delete();
            mem_q.delete();
            m_pc = RST_PC;
        end else begin
            fire_exp = exp_rv && imem_req_ready;
            if (imem_rsp_valid) void'(mem_q.pop_front());
            if (imem_req_valid && imem_req_ready) mem_q.push_back('{imem_req_addr, cyc + lat});
            if (exp_iv && instr_ready) void'(m_q.pop_front());
            if (imem_rsp_valid) begin
                check("rsp_matches_request", (m_infl.size() != 0), 1);
                if (m_infl.size() != 0) begin
                    f = m_infl.pop_front();
                    if (f.epoch == epoch && !redirect_valid) m_q.push_back('{f.pc, memfn(f.pc)});
                end
            end
            if (redirect_valid) begin
                m_q.delete();
                epoch++;
                m_pc = redirect_pc & ~32'h3;
            end else if (fire_exp) begin
                m_infl.push_back('{m_pc, epoch});
                m_pc += 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int unsigned n, input int unsigned rr, input int unsigned ir,
                       input int unsigned rd, input int unsigned rs, input int unsigned l);
        p_rr = rr; p_ir = ir; p_redir = rd; p_rst = rs; lat = l;
        repeat (n) cycle();
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        repeat (3) begin force_reset = 1'b1; cycle(); end
        run(20, 100, 100, 0, 0, 1);                     // streaming from 0x100

        force_reset = 1'b1; run(1, 100, 0, 0, 0, 1);
        fires = 0;
        run(20, 100, 0, 0, 0, 1);                       // pipeline stalled downstream
        check("bp_request_count", fires, DEPTH);
        check("bp_req_valid_low", imem_req_valid, 0);
        run(10, 100, 100, 0, 0, 1);                     // drain

        run(8, 100, 100, 0, 0, 3);
        force_redir = 1'b1; force_target = 32'h2002;
        run(14, 100, 100, 0, 0, 3);                     // redirect with requests in flight

        run(6, 100, 100, 0, 0, 1);
        force_redir = 1'b1; force_target = 32'h3000;
        run(8, 100, 100, 0, 0, 1);                      // redirect with response and pop

        run(5, 0, 100, 0, 0, 1);                        // memory stall
        run(8, 100, 100, 0, 0, 1);

        force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
        run(10, 100, 100, 0, 0, 1);                     // PC wrap
        force_reset = 1'b1;
        run(6, 100, 100, 0, 0, 1);                      // mid-stream reset

        for (int k = 0; k < 6; k++) begin
            run(300, $urandom_range(100, 30), $urandom_range(100, 20), 5, 1, $urandom_range(4, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
